cpu_fetch_queue: RTL and testbench
==================================

CPU_FETCH_QUEUE -- requirements
Module: CPU_FetchQueue

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch PC after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-003 SHALL have one clock, i_clock, and one reset, i_reset; reset is asynchronous and active-high.
REQ-004 i_clock  in  1  clock, all state on rising edge.
REQ-005 i_reset  in  1  asynchronous active-high reset.
REQ-006 o_ic_pc  out  32  fetch PC presented to instruction cache.
REQ-007 o_ic_stall  out  1  cache must hold current response.
REQ-008 i_ic_ready  in  1  i_ic_rdata valid for o_ic_pc this cycle.
REQ-009 i_ic_rdata  in  32  instruction word.
REQ-010 i_jump  in  1  branch resolved; i_jump_pc valid.
REQ-011 i_jump_pc  in  32  branch target.
REQ-012 i_irq_pending  in  1  interrupt request level.
REQ-013 i_irq_pc  in  32  interrupt handler vector.
REQ-014 o_irq_dispatched  out  1  one-cycle pulse, interrupt taken.
REQ-015 o_irq_epc  out  32  return PC of taken interrupt.
REQ-016 o_valid  out  1  queue head valid.
REQ-017 i_ready  in  1  decode accepts head this cycle.
REQ-018 o_instruction / o_pc  out  32 / 32  head instruction and its PC.
REQ-019 o_rs1 / o_rs2 / o_rd  out  5 each  pre-decoded register indices, 0 when field unused.
REQ-020 o_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy.

Function
REQ-021 States SHALL be FETCH, WAIT_JUMP, WAIT_IRQ; any other encoding returns to FETCH next cycle.
REQ-022 o_ic_stall SHALL be 1 when state != FETCH or count == QUEUE_DEPTH.
REQ-023 FETCH, i_ic_ready, not full, no IRQ edge: push {rdata, pc, rs1, rs2, rd}; pc <= pc+4 (mod 2^32).
REQ-024 Pushed entry SHALL appear on o_valid the next cycle (1-cycle latency); head outputs combinational from storage.
REQ-025 Pop SHALL occur when o_valid && i_ready; simultaneous push and pop leaves count unchanged; pop with empty queue is ignored.
REQ-026 Full queue: i_ic_ready ignored, pc held, no push.
REQ-027 Pushed JAL, JALR, BRANCH opcode or MRET (32'h30200073): state <= WAIT_JUMP.
REQ-028 Pushed ECALL (32'h00000073) or WFI (32'h10500073): state <= WAIT_IRQ.
REQ-029 WAIT_JUMP with i_jump: pc <= i_jump_pc, state <= FETCH; queue contents SHALL NOT be flushed; i_jump in other states ignored.
REQ-030 IRQ edge = i_irq_pending high and previous sampled value low; sampling register updated in FETCH only when i_ic_ready, and every cycle in WAIT_IRQ.
REQ-031 IRQ edge in FETCH with i_ic_ready: no push; o_irq_dispatched <= 1; o_irq_epc <= pc; pc <= i_irq_pc; queued entries retained.
REQ-032 IRQ edge in WAIT_IRQ: same as REQ-031 plus state <= FETCH.
REQ-033 IRQ edge and full queue in FETCH: IRQ taken (REQ-031 has priority over REQ-026).
REQ-034 rs1 valid for B, I, R, S, CSR, R4 formats; rs2 for B, R, S, R4; rd for I, J, R, U, CSR, R4.
REQ-035 Pointers SHALL wrap modulo QUEUE_DEPTH; count never exceeds QUEUE_DEPTH.

Reset
REQ-036 On i_reset: state FETCH, pc RESET_VECTOR, count 0, pointers 0, IRQ sample 0, o_irq_dispatched 0, o_irq_epc 0, o_valid 0.
REQ-037 Reset mid-operation SHALL discard queue and pending WAIT states; first fetch after release at RESET_VECTOR.
REQ-038 Queue storage need not be reset.

Structure
REQ-039 Opcode constants, MRET/ECALL/WFI encodings and fetch_entry_t {instruction, pc, rs1, rs2, rd} SHALL live in the shared CPU defines package.
REQ-040 Storage SHALL be a sub-module CPU_FetchFifo (QUEUE_DEPTH, entry type); control FSM in CPU_FetchQueue.

Verification
REQ-041 Reset, cache returns 4 NOPs at 0x0..0xC, i_ready=1 -> o_pc 0x0,0x4,0x8,0xC on consecutive cycles, count ≤1.
REQ-042 i_ready=0, QUEUE_DEPTH=4, cache always ready -> count reaches 4, o_ic_stall=1, o_ic_pc holds 0x10.
REQ-043 JAL at 0x8 -> state WAIT_JUMP, no further push; i_jump_pc=0x100 -> next o_ic_pc 0x100, entries 0x0..0x8 still delivered.
REQ-044 i_irq_pending rises at fetch of pc 0x20, i_irq_pc=0x200 -> o_irq_dispatched pulse, o_irq_epc=0x20, next o_ic_pc 0x200; held high -> no second dispatch.
REQ-045 WFI at 0x40, then irq rise -> dispatch with o_irq_epc=0x44, state FETCH.
REQ-046 Assert i_reset with queue count 3 in WAIT_JUMP -> count 0, o_valid 0, o_ic_pc RESET_VECTOR.

Source files
------------

// File: rtl/cpu_fetch_queue_pkg.sv
// Shared CPU defines: opcodes, special system encodings, fetch-queue entry type
// and the pre-decode helpers used by the fetch front end.
package cpu_fetch_queue_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_AMO       = 7'b0101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MADD      = 7'b1000011;
    localparam logic [6:0] OPC_MSUB      = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB     = 7'b1001011;
    localparam logic [6:0] OPC_NMADD     = 7'b1001111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;
    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSTR_WFI   = 32'h1050_0073;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT_JUMP = 2'd1,
        ST_WAIT_IRQ  = 2'd2
    } fetch_state_e;

    typedef enum logic [3:0] {
        FMT_NONE, FMT_R, FMT_R4, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR
    } instr_fmt_e;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } fetch_entry_t;

    function automatic instr_fmt_e get_format(input logic [31:0] instr);
        instr_fmt_e fmt;
        case (instr[6:0])
            OPC_OP, OPC_OP_32, OPC_AMO:                     fmt = FMT_R;
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD:       fmt = FMT_R4;
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD,
            OPC_JALR, OPC_MISC_MEM:                         fmt = FMT_I;
            OPC_STORE:                                      fmt = FMT_S;
            OPC_BRANCH:                                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                             fmt = FMT_U;
            OPC_JAL:                                        fmt = FMT_J;
            // funct3 == 0 is ECALL/EBREAK/MRET/WFI, which carry no register operands
            OPC_SYSTEM: fmt = (instr[14:12] != 3'b000) ? FMT_CSR : FMT_NONE;
            default:                                        fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    function automatic fetch_entry_t predecode(input logic [31:0] instr, input logic [31:0] pc);
        fetch_entry_t entry;
        instr_fmt_e   fmt;
        fmt               = get_format(instr);
        entry.instruction = instr;
        entry.pc          = pc;
        entry.rs1 = (fmt inside {FMT_B, FMT_I, FMT_R, FMT_S, FMT_CSR, FMT_R4}) ? instr[19:15] : 5'd0;
        entry.rs2 = (fmt inside {FMT_B, FMT_R, FMT_S, FMT_R4}) ? instr[24:20] : 5'd0;
        entry.rd  = (fmt inside {FMT_I, FMT_J, FMT_R, FMT_U, FMT_CSR, FMT_R4}) ? instr[11:7] : 5'd0;
        return entry;
    endfunction

    function automatic logic is_flow_change(input logic [31:0] instr);
        return (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_JALR) ||
               (instr[6:0] == OPC_BRANCH) || (instr == INSTR_MRET);
    endfunction

    function automatic logic is_wait_irq(input logic [31:0] instr);
        return (instr == INSTR_ECALL) || (instr == INSTR_WFI);
    endfunction

endpackage

// File: rtl/cpu_fetch_queue_fifo.sv
// Circular instruction queue: power-of-two depth, combinational head, push/pop
// are silently dropped when full/empty respectively.
module cpu_fetch_queue_fifo
    import cpu_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  entry_t                 i_push_data,
    input  logic                   i_pop,
    output entry_t                 o_head,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == FULL_COUNT);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && o_valid;

    // NOTE: storage has no reset; occupancy tracking alone decides what is valid,
    // which keeps the array a plain RAM without a reset fan-out.
    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Depth is a power of two, so pointer wrap is free natural overflow.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_fetch_queue.sv
// Fetch front end: drives the I-cache PC, pre-decodes returned words into the
// queue, and stalls on control flow (WAIT_JUMP) or ECALL/WFI (WAIT_IRQ).
module cpu_fetch_queue
    import cpu_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    output logic [31:0]                  o_ic_pc,
    output logic                         o_ic_stall,
    input  logic                         i_ic_ready,
    input  logic [31:0]                  i_ic_rdata,
    input  logic                         i_jump,
    input  logic [31:0]                  i_jump_pc,
    input  logic                         i_irq_pending,
    input  logic [31:0]                  i_irq_pc,
    output logic                         o_irq_dispatched,
    output logic [31:0]                  o_irq_epc,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [31:0]                  o_instruction,
    output logic [31:0]                  o_pc,
    output logic [4:0]                   o_rs1,
    output logic [4:0]                   o_rs2,
    output logic [4:0]                   o_rd,
    output logic [$clog2(QUEUE_DEPTH):0] o_count
);
    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic         r_irq_sample, w_irq_sample_next;
    logic         r_irq_dispatched, w_irq_dispatched_next;
    logic [31:0]  r_irq_epc, w_irq_epc_next;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_irq_edge;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_irq_edge   = i_irq_pending && !r_irq_sample;
    assign w_push_entry = predecode(i_ic_rdata, r_pc);
    assign w_pop        = o_valid && i_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next          = r_state;
        w_pc_next             = r_pc;
        w_irq_sample_next     = r_irq_sample;
        w_irq_dispatched_next = 1'b0;
        w_irq_epc_next        = r_irq_epc;
        w_push                = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // An interrupt edge wins over a full queue; the fetched word is dropped.
                if (i_ic_ready) begin
                    w_irq_sample_next = i_irq_pending;
                    if (w_irq_edge) begin
                        w_irq_dispatched_next = 1'b1;
                        w_irq_epc_next        = r_pc;
                        w_pc_next             = i_irq_pc;
                    end else if (!w_full) begin
                        w_push    = 1'b1;
                        w_pc_next = r_pc + 32'd4;
                        if (is_flow_change(i_ic_rdata)) begin
                            w_state_next = ST_WAIT_JUMP;
                        end else if (is_wait_irq(i_ic_rdata)) begin
                            w_state_next = ST_WAIT_IRQ;
                        end
                    end
                end
            end
            ST_WAIT_JUMP: begin
                if (i_jump) begin
                    w_pc_next    = i_jump_pc;
                    w_state_next = ST_FETCH;
                end
            end
            ST_WAIT_IRQ: begin
                w_irq_sample_next = i_irq_pending;
                if (w_irq_edge) begin
                    w_irq_dispatched_next = 1'b1;
                    w_irq_epc_next        = r_pc;
                    w_pc_next             = i_irq_pc;
                    w_state_next          = ST_FETCH;
                end
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= ST_FETCH;
            r_pc             <= RESET_VECTOR;
            r_irq_sample     <= 1'b0;
            r_irq_dispatched <= 1'b0;
            r_irq_epc        <= 32'd0;
        end else begin
            r_state          <= w_state_next;
            r_pc             <= w_pc_next;
            r_irq_sample     <= w_irq_sample_next;
            r_irq_dispatched <= w_irq_dispatched_next;
            r_irq_epc        <= w_irq_epc_next;
        end
    end

    cpu_fetch_queue_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (o_valid),
        .o_full      (w_full),
        .o_count     (o_count)
    );

    assign o_ic_pc          = r_pc;
    assign o_ic_stall       = (r_state != ST_FETCH) || w_full;
    assign o_irq_dispatched = r_irq_dispatched;
    assign o_irq_epc        = r_irq_epc;
    assign o_instruction    = w_head.instruction;
    assign o_pc             = w_head.pc;
    assign o_rs1            = w_head.rs1;
    assign o_rs2            = w_head.rs2;
    assign o_rd             = w_head.rd;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Bench for cpu_fetch_queue: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based behavioural model.
module tb_cpu_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL1  = 32'h0080_00EF;
    localparam logic [31:0] WFI   = 32'h1050_0073;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] MRET  = 32'h3020_0073;
    localparam int MODE_FETCH = 0, MODE_JUMP = 1, MODE_IRQ = 2;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ic_ready = 1'b0, i_jump = 1'b0, i_irq_pending = 1'b0, i_ready = 1'b0;
    logic [31:0] i_ic_rdata = 32'd0, i_jump_pc = 32'd0, i_irq_pc = 32'd0;
    logic [31:0] o_ic_pc, o_irq_epc, o_instruction, o_pc;
    logic        o_ic_stall, o_irq_dispatched, o_valid;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;
    bit rand_mode = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] m_pc = RV;
    int          m_mode = MODE_FETCH;
    bit          m_prev = 0;
    bit          m_disp = 0;
    logic [31:0] m_epc = 32'd0;
    logic [31:0] mem [logic [31:0]];

    cpu_fetch_queue #(.RESET_VECTOR(RV), .QUEUE_DEPTH(DEPTH)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .o_ic_pc(o_ic_pc), .o_ic_stall(o_ic_stall),
        .i_ic_ready(i_ic_ready), .i_ic_rdata(i_ic_rdata),
        .i_jump(i_jump), .i_jump_pc(i_jump_pc),
        .i_irq_pending(i_irq_pending), .i_irq_pc(i_irq_pc),
        .o_irq_dispatched(o_irq_dispatched), .o_irq_epc(o_irq_epc),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_instruction(o_instruction), .o_pc(o_pc),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_count(o_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand usage per opcode as {rs1, rs2, rd}.
    function automatic logic [2:0] field_use(input logic [31:0] w);
        case (w[6:0])
            7'h33, 7'h3B, 7'h2F, 7'h43, 7'h47, 7'h4B, 7'h4F: return 3'b111;
            7'h13, 7'h1B, 7'h03, 7'h67, 7'h0F:               return 3'b101;
            7'h23, 7'h63:                                    return 3'b110;
            7'h37, 7'h17, 7'h6F:                             return 3'b001;
            7'h73:   return (w[14:12] != 3'b000) ? 3'b101 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t make_entry(input logic [31:0] w, input logic [31:0] pc);
        exp_t       e;
        logic [2:0] u;
        u       = field_use(w);
        e.instr = w;
        e.pc    = pc;
        e.rs1   = u[2] ? w[19:15] : 5'd0;
        e.rs2   = u[1] ? w[24:20] : 5'd0;
        e.rd    = u[0] ? w[11:7]  : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : NOP;
    endfunction

    task automatic model_step();
        bit   pop, push, rise;
        exp_t e;
        pop    = (mq.size() != 0) && i_ready;
        rise   = i_irq_pending && !m_prev;
        push   = 0;
        m_disp = 0;
        if (m_mode == MODE_FETCH) begin
            if (i_ic_ready) begin
                m_prev = i_irq_pending;
                if (rise) begin
                    m_disp = 1; m_epc = m_pc; m_pc = i_irq_pc;
                end else if (mq.size() < DEPTH) begin
                    e    = make_entry(i_ic_rdata, m_pc);
                    push = 1;
                    m_pc = m_pc + 32'd4;
                    if (i_ic_rdata[6:0] inside {7'h6F, 7'h67, 7'h63} || i_ic_rdata == MRET)
                        m_mode = MODE_JUMP;
                    else if (i_ic_rdata == ECALL || i_ic_rdata == WFI)
                        m_mode = MODE_IRQ;
                end
            end
        end else if (m_mode == MODE_JUMP) begin
            if (i_jump) begin
                m_pc = i_jump_pc; m_mode = MODE_FETCH;
            end
        end else begin
            m_prev = i_irq_pending;
            if (rise) begin
                m_disp = 1; m_epc = m_pc; m_pc = i_irq_pc; m_mode = MODE_FETCH;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
    endtask

    initial forever begin
        @(posedge i_clock or posedge i_reset);
        if (i_reset) begin
            mq.delete(); m_pc = RV; m_mode = MODE_FETCH; m_prev = 0; m_disp = 0; m_epc = 32'd0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge i_clock);
        if (chk_en && !i_reset) begin
            check("ic_pc", o_ic_pc, m_pc);
            check("ic_stall", 32'(o_ic_stall), 32'(m_mode != MODE_FETCH || mq.size() == DEPTH));
            check("valid", 32'(o_valid), 32'(mq.size() != 0));
            check("count", 32'(o_count), 32'(mq.size()));
            check("irq_dispatched", 32'(o_irq_dispatched), 32'(m_disp));
            check("irq_epc", o_irq_epc, m_epc);
            if (mq.size() != 0) begin
                check("head_instr", o_instruction, mq[0].instr);
                check("head_pc", o_pc, mq[0].pc);
                check("head_rs1", 32'(o_rs1), 32'(mq[0].rs1));
                check("head_rs2", 32'(o_rs2), 32'(mq[0].rs2));
                check("head_rd", 32'(o_rd), 32'(mq[0].rd));
            end
        end
    end

    task automatic tick();
        @(negedge i_clock);
        if (!rand_mode) i_ic_rdata = mem_word(o_ic_pc);
    endtask

    task automatic do_reset();
        @(negedge i_clock);
        chk_en = 0;
        i_reset = 1; i_ready = 0; i_ic_ready = 0; i_jump = 0; i_jump_pc = 0;
        i_irq_pending = 0; i_irq_pc = 0;
        @(negedge i_clock);
        check("rst_ic_pc", o_ic_pc, RV);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_stall", 32'(o_ic_stall), 32'd0);
        check("rst_disp", 32'(o_irq_dispatched), 32'd0);
        check("rst_epc", o_irq_epc, 32'd0);
        i_reset = 0;
        chk_en = 1;
        i_ic_rdata = rand_mode ? NOP : mem_word(o_ic_pc);
    endtask

    function automatic logic [31:0] pick_instr();
        case ($urandom_range(0, 15))
            0:  return NOP;
            1:  return 32'h0020_81B3;  // add x3,x1,x2
            2:  return 32'h0020_A023;  // sw x2,0(x1)
            3:  return 32'h0020_8463;  // beq x1,x2
            4:  return JAL1;
            5:  return 32'h0002_80E7;  // jalr x1,0(x5)
            6:  return 32'h1234_52B7;  // lui x5
            7:  return 32'h0000_1297;  // auipc x5
            8:  return 32'h0043_A303;  // lw x6,4(x7)
            9:  return 32'h3001_10F3;  // csrrw x1,mstatus,x2
            10: return ECALL;
            11: return WFI;
            12: return MRET;
            13: return 32'h1820_F543;  // fmadd (R4)
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ready_bias;

        // Four NOPs streamed straight through with decode always ready.
        mem.delete();
        do_reset();
        i_ready = 1; i_ic_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("s1_head_pc", o_pc, 32'(4 * k));
            check("s1_count", 32'(o_count), 32'd1);
        end

        // Decode blocked: queue fills and fetch PC holds.
        mem.delete();
        do_reset();
        i_ready = 0; i_ic_ready = 1;
        repeat (6) tick();
        check("s2_count", 32'(o_count), 32'd4);
        check("s2_stall", 32'(o_ic_stall), 32'd1);
        check("s2_ic_pc", o_ic_pc, 32'h10);

        // JAL at 0x8 waits for resolution; queued entries survive the redirect.
        mem.delete();
        mem[32'h8] = JAL1;
        do_reset();
        i_ready = 0; i_ic_ready = 1;
        repeat (5) tick();
        check("s3_count", 32'(o_count), 32'd3);
        check("s3_ic_pc", o_ic_pc, 32'hC);
        i_jump = 1; i_jump_pc = 32'h100;
        tick();
        i_jump = 0;
        check("s3_jump_pc", o_ic_pc, 32'h100);
        check("s3_head0", o_pc, 32'h0);
        i_ready = 1;
        tick();
        check("s3_head1", o_pc, 32'h4);
        tick();
        check("s3_head2", o_pc, 32'h8);
        check("s3_head2_rd", 32'(o_rd), 32'd1);
        tick();
        check("s3_head3", o_pc, 32'h100);

        // Interrupt edge during fetch of 0x20; level held gives one dispatch only.
        mem.delete();
        do_reset();
        i_ready = 1; i_ic_ready = 1;
        repeat (8) tick();
        check("s4_pre_pc", o_ic_pc, 32'h20);
        i_irq_pending = 1; i_irq_pc = 32'h200;
        tick();
        check("s4_disp", 32'(o_irq_dispatched), 32'd1);
        check("s4_epc", o_irq_epc, 32'h20);
        check("s4_vec", o_ic_pc, 32'h200);
        tick();
        check("s4_no_redisp", 32'(o_irq_dispatched), 32'd0);
        check("s4_next_pc", o_ic_pc, 32'h204);

        // WFI at 0x40 parks fetch until an interrupt edge.
        mem.delete();
        mem[32'h40] = WFI;
        do_reset();
        i_ready = 1; i_ic_ready = 1;
        repeat (17) tick();
        check("s5_wait_pc", o_ic_pc, 32'h44);
        check("s5_wait_stall", 32'(o_ic_stall), 32'd1);
        repeat (2) tick();
        i_irq_pending = 1; i_irq_pc = 32'h300;
        tick();
        check("s5_disp", 32'(o_irq_dispatched), 32'd1);
        check("s5_epc", o_irq_epc, 32'h44);
        check("s5_vec", o_ic_pc, 32'h300);
        check("s5_stall", 32'(o_ic_stall), 32'd0);
        i_irq_pending = 0;

        // Asynchronous reset while three entries wait behind a JAL.
        mem.delete();
        mem[32'h8] = JAL1;
        do_reset();
        i_ready = 0; i_ic_ready = 1;
        repeat (4) tick();
        check("s6_pre_count", 32'(o_count), 32'd3);
        chk_en = 0;
        i_reset = 1;
        #1;
        check("s6_count", 32'(o_count), 32'd0);
        check("s6_valid", 32'(o_valid), 32'd0);
        check("s6_ic_pc", o_ic_pc, RV);
        @(negedge i_clock);
        i_reset = 0;
        chk_en = 1;
        i_ic_rdata = mem_word(o_ic_pc);
        tick();
        check("s6_first_pc", o_pc, RV);

        // Random traffic against the model.
        mem.delete();
        rand_mode = 1;
        do_reset();
        ready_bias = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) ready_bias = $urandom_range(0, 4);
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
            i_ready       = ($urandom_range(0, 3) < ready_bias);
            i_ic_ready    = ($urandom_range(0, 3) != 0);
            i_ic_rdata    = pick_instr();
            i_jump        = ($urandom_range(0, 3) == 0);
            i_jump_pc     = $urandom & 32'hFFFF_FFFC;
            i_irq_pc      = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) i_irq_pending = ~i_irq_pending;
        end
        tick();
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
